// File: rtl/axi4_lite_pkg.sv
// Shared types and helpers for the AXI4-Lite register file slave.
// Response codes, FSM state encodings and byte-strobe merge.
package axi4_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {
    WR_IDLE,
    WR_RESP
  } wr_state_e;

  typedef enum logic {
    RD_IDLE,
    RD_DATA
  } rd_state_e;

  // One byte lane of a strobed write: keep old unless enabled.
  function automatic logic [7:0] strb_merge(
    input logic [7:0] old,
    input logic [7:0] data,
    input logic       strb
  );
    return strb ? data : old;
  endfunction

endpackage

// File: rtl/axi4_lite_regbank.sv
// Register array with one strobed write port and one async read port.
// All registers are also exported flat on reg_q.
module axi4_lite_regbank
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int IW         = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic                           we,
  input  logic [IW-1:0]                  widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [IW-1:0]                  ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int SW = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] regs [NUM_REGS];
  logic [DATA_WIDTH-1:0] merged;

  always_comb begin
    merged = regs[widx];
    for (int b = 0; b < SW; b++) begin
      merged[b*8 +: 8] = strb_merge(regs[widx][b*8 +: 8],
                                    wdata[b*8 +: 8], wstrb[b]);
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[widx] <= merged;
    end
  end

  // Guard covers non-power-of-two NUM_REGS where ridx can overrun.
  assign rdata = (32'(ridx) < NUM_REGS) ? regs[ridx] : '0;

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_flat
    assign reg_q[i*DATA_WIDTH +: DATA_WIDTH] = regs[i];
  end

endmodule

// File: rtl/axi4_lite_slave_regfile.sv
// AXI4-Lite slave register file: independent AW/W capture, held B/R,
// SLVERR on out-of-range index, registered handshake outputs.
module axi4_lite_slave_regfile
  import axi4_lite_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_REGS   = 8,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                           ACLK,
  input  logic                           ARESETn,
  input  logic [ADDR_WIDTH-1:0]          AWADDR,
  input  logic                           AWVALID,
  output logic                           AWREADY,
  input  logic [DATA_WIDTH-1:0]          WDATA,
  input  logic [DATA_WIDTH/8-1:0]        WSTRB,
  input  logic                           WVALID,
  output logic                           WREADY,
  output logic [1:0]                     BRESP,
  output logic                           BVALID,
  input  logic                           BREADY,
  input  logic [ADDR_WIDTH-1:0]          ARADDR,
  input  logic                           ARVALID,
  output logic                           ARREADY,
  output logic [DATA_WIDTH-1:0]          RDATA,
  output logic [1:0]                     RRESP,
  output logic                           RVALID,
  input  logic                           RREADY,
  output logic [NUM_REGS*DATA_WIDTH-1:0] reg_q
);

  localparam int SW  = DATA_WIDTH / 8;
  localparam int LSB = $clog2(SW);
  localparam int IXW = ADDR_WIDTH - LSB;
  localparam int IW  = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  wr_state_e wr_state;
  rd_state_e rd_state;

  logic                  aw_held;
  logic                  w_held;
  logic [IXW-1:0]        aw_idx_q;
  logic [DATA_WIDTH-1:0] wdata_q;
  logic [SW-1:0]         wstrb_q;

  logic                  aw_hs;
  logic                  w_hs;
  logic                  ar_hs;
  logic                  wr_commit;
  logic                  wr_in_range;
  logic                  rd_in_range;
  logic [IXW-1:0]        wr_idx;
  logic [IXW-1:0]        ar_idx;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [SW-1:0]         wr_strb;
  logic [DATA_WIDTH-1:0] rb_rdata;
  logic                  unused_addr_bits;

  assign aw_hs = AWVALID && AWREADY;
  assign w_hs  = WVALID && WREADY;
  assign ar_hs = ARVALID && ARREADY;

  // A held channel wins; otherwise use the live bus this cycle.
  assign wr_idx  = aw_held ? aw_idx_q : AWADDR[ADDR_WIDTH-1:LSB];
  assign wr_data = w_held ? wdata_q : WDATA;
  assign wr_strb = w_held ? wstrb_q : WSTRB;
  assign ar_idx  = ARADDR[ADDR_WIDTH-1:LSB];

  assign wr_in_range = 32'(wr_idx) < NUM_REGS;
  assign rd_in_range = 32'(ar_idx) < NUM_REGS;

  assign wr_commit = (wr_state == WR_IDLE)
                  && (aw_held || aw_hs)
                  && (w_held || w_hs);

  assign unused_addr_bits = ^{AWADDR[LSB-1:0], ARADDR[LSB-1:0]};

  axi4_lite_regbank #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_REGS   (NUM_REGS),
    .IW         (IW)
  ) u_regbank (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .we      (wr_commit && wr_in_range),
    .widx    (IW'(wr_idx)),
    .wdata   (wr_data),
    .wstrb   (wr_strb),
    .ridx    (IW'(ar_idx)),
    .rdata   (rb_rdata),
    .reg_q   (reg_q)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      wr_state <= WR_IDLE;
      aw_held  <= 1'b0;
      w_held   <= 1'b0;
      aw_idx_q <= '0;
      wdata_q  <= '0;
      wstrb_q  <= '0;
      AWREADY  <= 1'b0;
      WREADY   <= 1'b0;
      BVALID   <= 1'b0;
      BRESP    <= RESP_OKAY;
    end else begin
      unique case (wr_state)
        WR_IDLE: begin
          if (wr_commit) begin
            wr_state <= WR_RESP;
            aw_held  <= 1'b0;
            w_held   <= 1'b0;
            AWREADY  <= 1'b0;
            WREADY   <= 1'b0;
            BVALID   <= 1'b1;
            BRESP    <= wr_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            if (aw_hs) begin
              aw_held  <= 1'b1;
              aw_idx_q <= AWADDR[ADDR_WIDTH-1:LSB];
            end
            if (w_hs) begin
              w_held  <= 1'b1;
              wdata_q <= WDATA;
              wstrb_q <= WSTRB;
            end
            AWREADY <= !(aw_held || aw_hs);
            WREADY  <= !(w_held || w_hs);
          end
        end
        WR_RESP: begin
          if (BREADY) begin
            wr_state <= WR_IDLE;
            BVALID   <= 1'b0;
            AWREADY  <= 1'b1;
            WREADY   <= 1'b1;
          end
        end
        default: wr_state <= WR_IDLE;
      endcase
    end
  end

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      rd_state <= RD_IDLE;
      ARREADY  <= 1'b0;
      RVALID   <= 1'b0;
      RDATA    <= '0;
      RRESP    <= RESP_OKAY;
    end else begin
      unique case (rd_state)
        RD_IDLE: begin
          if (ar_hs) begin
            rd_state <= RD_DATA;
            ARREADY  <= 1'b0;
            RVALID   <= 1'b1;
            RDATA    <= rd_in_range ? rb_rdata : '0;
            RRESP    <= rd_in_range ? RESP_OKAY : RESP_SLVERR;
          end else begin
            ARREADY <= 1'b1;
          end
        end
        RD_DATA: begin
          if (RREADY) begin
            rd_state <= RD_IDLE;
            RVALID   <= 1'b0;
            ARREADY  <= 1'b1;
          end
        end
        default: rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_lite_slave_regfile.sv
// Bench for axi4_lite_slave_regfile: transaction-level model plus
// directed scenarios with literal expectations.
module tb_axi4_lite_slave_regfile;

  localparam int DW = 32;
  localparam int NR = 8;
  localparam int AW = 6;
  localparam int SW = DW / 8;

  logic            ACLK = 1'b0;
  logic            ARESETn = 1'b0;
  logic [AW-1:0]   AWADDR = '0;
  logic            AWVALID = 1'b0;
  logic            AWREADY;
  logic [DW-1:0]   WDATA = '0;
  logic [SW-1:0]   WSTRB = '0;
  logic            WVALID = 1'b0;
  logic            WREADY;
  logic [1:0]      BRESP;
  logic            BVALID;
  logic            BREADY = 1'b0;
  logic [AW-1:0]   ARADDR = '0;
  logic            ARVALID = 1'b0;
  logic            ARREADY;
  logic [DW-1:0]   RDATA;
  logic [1:0]      RRESP;
  logic            RVALID;
  logic            RREADY = 1'b0;
  logic [NR*DW-1:0] reg_q;

  int errors = 0;
  int checks = 0;

  axi4_lite_slave_regfile #(
    .DATA_WIDTH (DW),
    .NUM_REGS   (NR),
    .ADDR_WIDTH (AW)
  ) dut (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .AWADDR  (AWADDR),
    .AWVALID (AWVALID),
    .AWREADY (AWREADY),
    .WDATA   (WDATA),
    .WSTRB   (WSTRB),
    .WVALID  (WVALID),
    .WREADY  (WREADY),
    .BRESP   (BRESP),
    .BVALID  (BVALID),
    .BREADY  (BREADY),
    .ARADDR  (ARADDR),
    .ARVALID (ARVALID),
    .ARREADY (ARREADY),
    .RDATA   (RDATA),
    .RRESP   (RRESP),
    .RVALID  (RVALID),
    .RREADY  (RREADY),
    .reg_q   (reg_q)
  );

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [NR*DW-1:0] act,
                     input logic [NR*DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] m_regs [NR];
  logic [AW-1:0] awq [$];
  logic [DW+SW-1:0] wq [$];
  logic [1:0]    bq [$];
  logic [DW+1:0] rq [$];

  always @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      for (int i = 0; i < NR; i++) m_regs[i] = '0;
      awq.delete(); wq.delete(); bq.delete(); rq.delete();
    end else begin
      int ridx;
      int widx;
      logic [AW-1:0] a;
      logic [DW+SW-1:0] wd;
      if (BVALID && BREADY && bq.size() > 0) void'(bq.pop_front());
      if (RVALID && RREADY && rq.size() > 0) void'(rq.pop_front());
      // Reads see register state from before any write on this edge.
      if (ARVALID && ARREADY) begin
        ridx = int'(ARADDR) / SW;
        if (ridx < NR) rq.push_back({2'b00, m_regs[ridx]});
        else           rq.push_back({2'b10, {DW{1'b0}}});
      end
      if (AWVALID && AWREADY) awq.push_back(AWADDR);
      if (WVALID && WREADY) wq.push_back({WSTRB, WDATA});
      if (awq.size() > 0 && wq.size() > 0) begin
        a = awq.pop_front();
        wd = wq.pop_front();
        widx = int'(a) / SW;
        if (widx < NR) begin
          for (int b = 0; b < SW; b++)
            if (wd[DW+b]) m_regs[widx][b*8 +: 8] = wd[b*8 +: 8];
          bq.push_back(2'b00);
        end else begin
          bq.push_back(2'b10);
        end
      end
    end
  end

  // ---------------- compare process ----------------
  always @(negedge ACLK) begin
    if (ARESETn) begin
      logic [NR*DW-1:0] exp_q;
      for (int i = 0; i < NR; i++) exp_q[i*DW +: DW] = m_regs[i];
      chk("reg_q", reg_q, exp_q);
      chk("bvalid", {{(NR*DW-1){1'b0}}, BVALID},
          {{(NR*DW-1){1'b0}}, bq.size() > 0});
      chk("rvalid", {{(NR*DW-1){1'b0}}, RVALID},
          {{(NR*DW-1){1'b0}}, rq.size() > 0});
      if (BVALID && bq.size() > 0) begin
        chk("bresp", {{(NR*DW-2){1'b0}}, BRESP},
            {{(NR*DW-2){1'b0}}, bq[0]});
        chk("aw_w_ready_in_resp", {{(NR*DW-2){1'b0}}, AWREADY, WREADY}, '0);
      end
      if (RVALID && rq.size() > 0) begin
        chk("rdata_rresp", {{(NR*DW-DW-2){1'b0}}, RRESP, RDATA},
            {{(NR*DW-DW-2){1'b0}}, rq[0]});
        chk("arready_in_data", {{(NR*DW-1){1'b0}}, ARREADY}, '0);
      end
    end
  end

  // ---------------- drivers (called just after a negedge) ----------------
  task automatic aw_send(input logic [AW-1:0] addr);
    int n = 0;
    AWADDR = addr; AWVALID = 1'b1;
    while (!AWREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("aw_handshake", {{(NR*DW-1){1'b0}}, AWREADY}, 1);
    @(negedge ACLK);
    AWVALID = 1'b0;
  endtask

  task automatic w_send(input logic [DW-1:0] d, input logic [SW-1:0] s);
    int n = 0;
    WDATA = d; WSTRB = s; WVALID = 1'b1;
    while (!WREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("w_handshake", {{(NR*DW-1){1'b0}}, WREADY}, 1);
    @(negedge ACLK);
    WVALID = 1'b0;
  endtask

  task automatic ar_send(input logic [AW-1:0] addr);
    int n = 0;
    ARADDR = addr; ARVALID = 1'b1;
    while (!ARREADY && n < 50) begin @(negedge ACLK); n++; end
    chk("ar_handshake", {{(NR*DW-1){1'b0}}, ARREADY}, 1);
    @(negedge ACLK);
    ARVALID = 1'b0;
  endtask

  task automatic b_take(output logic [1:0] resp, output int n);
    n = 0;
    BREADY = 1'b1;
    while (!BVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("b_wait", {{(NR*DW-1){1'b0}}, BVALID}, 1);
    resp = BRESP;
    @(negedge ACLK);
    BREADY = 1'b0;
  endtask

  task automatic r_take(output logic [DW-1:0] d, output logic [1:0] resp,
                        output int n);
    n = 0;
    RREADY = 1'b1;
    while (!RVALID && n < 50) begin @(negedge ACLK); n++; end
    chk("r_wait", {{(NR*DW-1){1'b0}}, RVALID}, 1);
    d = RDATA; resp = RRESP;
    @(negedge ACLK);
    RREADY = 1'b0;
  endtask

  task automatic write(input logic [AW-1:0] a, input logic [DW-1:0] d,
                       input logic [SW-1:0] s, output logic [1:0] resp);
    int n;
    fork
      aw_send(a);
      w_send(d, s);
    join
    b_take(resp, n);
  endtask

  task automatic read(input logic [AW-1:0] a, output logic [DW-1:0] d,
                      output logic [1:0] resp);
    int n;
    ar_send(a);
    r_take(d, resp, n);
    chk("r_latency", n, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  // ---------------- directed scenarios ----------------
  initial begin
    logic [1:0]       resp;
    logic [DW-1:0]    d;
    logic [NR*DW-1:0] snap;
    int               n;

    #12;
    chk("rst_bvalid", {{(NR*DW-1){1'b0}}, BVALID}, 0);
    chk("rst_rvalid", {{(NR*DW-1){1'b0}}, RVALID}, 0);
    chk("rst_ready", {{(NR*DW-3){1'b0}}, AWREADY, WREADY, ARREADY}, 0);
    chk("rst_rdata", {{(NR*DW-DW){1'b0}}, RDATA}, 0);
    chk("rst_reg_q", reg_q, 0);
    @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);

    // AW first, W three cycles later
    fork
      aw_send(6'h04);
      begin repeat (3) @(negedge ACLK); w_send(32'hDEADBEEF, 4'hF); end
    join
    b_take(resp, n);
    chk("t1_bresp", resp, 2'b00);
    chk("t1_blat", n, 0);
    read(6'h04, d, resp);
    chk("t1_rdata", d, 32'hDEADBEEF);
    chk("t1_rresp", resp, 2'b00);

    // W before AW with partial strobes
    write(6'h08, 32'h11223344, 4'hF, resp);
    fork
      w_send(32'hAABBCCDD, 4'b0101);
      begin repeat (2) @(negedge ACLK); aw_send(6'h08); end
    join
    b_take(resp, n);
    chk("t2_reg2", reg_q[2*DW +: DW], 32'h11BB33DD);
    chk("t2_bresp", resp, 2'b00);

    // Out-of-range write and read
    snap = reg_q;
    write(6'h20, 32'hFFFFFFFF, 4'hF, resp);
    chk("t3_bresp", resp, 2'b10);
    chk("t3_reg_q", reg_q, snap);
    read(6'h3C, d, resp);
    chk("t3_rdata", d, 0);
    chk("t3_rresp", resp, 2'b10);

    // Backpressure on both response channels
    fork
      aw_send(6'h0C);
      w_send(32'h0000CAFE, 4'hF);
      ar_send(6'h08);
    join
    repeat (5) @(negedge ACLK);
    b_take(resp, n);
    chk("t4_bresp", resp, 2'b00);
    r_take(d, resp, n);
    chk("t4_rdata", d, 32'h11BB33DD);
    chk("t4_reg3", reg_q[3*DW +: DW], 32'h0000CAFE);

    // Reset while both responses pending
    fork
      aw_send(6'h10);
      w_send(32'h12345678, 4'hF);
      ar_send(6'h04);
    join
    @(negedge ACLK);
    #2 ARESETn = 1'b0;
    #1;
    chk("t6_bvalid", {{(NR*DW-1){1'b0}}, BVALID}, 0);
    chk("t6_rvalid", {{(NR*DW-1){1'b0}}, RVALID}, 0);
    chk("t6_reg_q", reg_q, 0);
    repeat (2) @(negedge ACLK);
    ARESETn = 1'b1;
    @(negedge ACLK);
    write(6'h0C, 32'h00000077, 4'hF, resp);
    chk("t6_bresp", resp, 2'b00);
    read(6'h0C, d, resp);
    chk("t6_rdata", d, 32'h00000077);

    // Same-edge read and commit on idx 1
    w_send(32'h5A5A5A5A, 4'hF);
    fork
      aw_send(6'h04);
      ar_send(6'h04);
    join
    b_take(resp, n);
    r_take(d, resp, n);
    chk("t5_old", d, 32'h0);
    read(6'h05, d, resp);
    chk("t5_new", d, 32'h5A5A5A5A);

    repeat (2) @(negedge ACLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
